// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and round helper functions.
// IV_224 is only referenced when the block is built with SHA224_MODE_EN.
package sha256_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    // Working variables a..h; packing puts a (H0) in the top word, so the
    // chaining value reads directly as a big-endian digest.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam work_t IV_256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam work_t IV_224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic work_t add_work(input work_t x, input work_t y);
        work_t r;
        r.a = x.a + y.a;
        r.b = x.b + y.b;
        r.c = x.c + y.c;
        r.d = x.d + y.d;
        r.e = x.e + y.e;
        r.f = x.f + y.f;
        r.g = x.g + y.g;
        r.h = x.h + y.h;
        return r;
    endfunction

endpackage

// File: rtl/sha256_stream_if.sv
// Block-in / digest-out handshake bundle for sha256_stream.
// SHA224_MODE_EN adds the mode_224 select line.
interface sha256_stream_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] M_in;
    logic         in_first;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] H_out;
`ifdef SHA224_MODE_EN
    logic         mode_224;

    modport master (
        output in_valid, M_in, in_first, in_last, out_ready, mode_224,
        input  in_ready, out_valid, H_out
    );
    modport slave (
        input  in_valid, M_in, in_first, in_last, out_ready, mode_224,
        output in_ready, out_valid, H_out
    );
`else
    modport master (
        output in_valid, M_in, in_first, in_last, out_ready,
        input  in_ready, out_valid, H_out
    );
    modport slave (
        input  in_valid, M_in, in_first, in_last, out_ready,
        output in_ready, out_valid, H_out
    );
`endif
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: a..h plus W_t, K_t in, a..h out.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t       cur,
    input  logic [31:0] w,
    input  logic [31:0] k,
    output work_t       nxt
);
    logic [31:0] ch, maj, t1, t2;

    always_comb begin
        ch    = (cur.e & cur.f) ^ (~cur.e & cur.g);
        maj   = (cur.a & cur.b) ^ (cur.a & cur.c) ^ (cur.b & cur.c);
        t1    = cur.h + big_sigma1(cur.e) + ch + k + w;
        t2    = big_sigma0(cur.a) + maj;
        nxt.a = t1 + t2;
        nxt.b = cur.a;
        nxt.c = cur.b;
        nxt.d = cur.c;
        nxt.e = cur.d + t1;
        nxt.f = cur.e;
        nxt.g = cur.f;
        nxt.h = cur.g;
    end
endmodule

// File: rtl/sha256_stream.sv
// Streaming SHA-256 core: one 512-bit block per accept, ROUNDS_PER_CYCLE rounds/clock.
// Optional SHA224_MODE_EN adds a SHA-224 IV select and a truncated digest.
module sha256_stream
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input logic           clk,
    input logic           rst,
    sha256_stream_if.slave bus
);
    localparam int R = ROUNDS_PER_CYCLE;

    if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rounds
        $fatal(1, "sha256_stream: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    state_t             state_q, state_d;
    work_t              work_q, chain_q, iv_sel, digest;
    logic [15:0][31:0]  win_q, win_d, blk;
    logic [31:0]        ext [16+R];
    work_t              stage [R+1];
    logic [5:0]         rnd_cnt;
    logic               last_q, accept, last_rnd, rdy, vld;
`ifdef SHA224_MODE_EN
    logic               mode_q;
`endif

    assign blk      = bus.M_in;
    assign last_rnd = (rnd_cnt == 6'(64 - R));

`ifdef SHA224_MODE_EN
    assign iv_sel = bus.mode_224 ? IV_224 : IV_256;
`else
    assign iv_sel = IV_256;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        rdy     = 1'b0;
        vld     = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = ROUND;
                end
            end
            ROUND:   if (last_rnd) state_d = FINAL;
            FINAL:   state_d = last_q ? DONE : IDLE;
            DONE: begin
                vld = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Message schedule: extend the 16-word window by R words, then slide by R.
    always_comb begin
        for (int i = 0; i < 16; i++) ext[i] = win_q[i];
        for (int j = 0; j < R; j++)
            ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
        for (int i = 0; i < 16; i++) win_d[i] = ext[i+R];
    end

    assign stage[0] = work_q;
    for (genvar g = 0; g < R; g++) begin : g_rnd
        logic [5:0] kidx;
        assign kidx = rnd_cnt + 6'(g);
        sha256_round u_round (
            .cur (stage[g]),
            .w   (ext[g]),
            .k   (K[kidx]),
            .nxt (stage[g+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_cnt <= '0;
            chain_q <= IV_256;
            work_q  <= '0;
            win_q   <= '0;
            last_q  <= 1'b0;
`ifdef SHA224_MODE_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    for (int i = 0; i < 16; i++) win_q[i] <= blk[15-i];
                    last_q  <= bus.in_last;
                    rnd_cnt <= '0;
                    work_q  <= bus.in_first ? iv_sel : chain_q;
                    if (bus.in_first) begin
                        chain_q <= iv_sel;
`ifdef SHA224_MODE_EN
                        mode_q  <= bus.mode_224;
`endif
                    end
                end
                ROUND: begin
                    work_q  <= stage[R];
                    win_q   <= win_d;
                    rnd_cnt <= rnd_cnt + 6'(R);
                end
                FINAL: chain_q <= add_work(chain_q, work_q);
                // A finished message leaves the IV behind so an unflagged block still hashes cleanly.
                DONE: if (bus.out_ready) begin
                    chain_q <= IV_256;
`ifdef SHA224_MODE_EN
                    mode_q  <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        digest = chain_q;
`ifdef SHA224_MODE_EN
        if (mode_q) digest.h = '0;
`endif
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.H_out     = vld ? digest : '0;

endmodule

// File: tb/tb_sha256_stream.sv
// Directed bench for sha256_stream: R=1 and R=4 instances, known-answer digests.
// Build with SHA224_MODE_EN to add the SHA-224 scenario.
module tb_sha256_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sha256_stream_if b1();
    sha256_stream_if b4();

    sha256_stream #(.ROUNDS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    sha256_stream #(.ROUNDS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    localparam logic [511:0] MSG_ABC  = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] MSG_NULL = {32'h80000000, 480'h0};
    localparam logic [511:0] MSG_2A   = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] MSG_2B   = {480'h0, 32'h000001c0};
    localparam logic [255:0] DIG_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_2    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] DIG_NULL = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_224  = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
    localparam logic [511:0] JUNK     = {16{32'hdeadbeef}};

    int n_cmp = 0;
    int n_bad = 0;

    // Offer a block on b1 and return #1 after the edge that takes it; inputs are then scrambled.
    task automatic accept1(input logic [511:0] m, input logic first, input logic last);
        b1.M_in = m; b1.in_first = first; b1.in_last = last; b1.in_valid = 1'b1;
        for (int i = 0; i < 200 && !b1.in_ready; i++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        b1.in_valid = 1'b0; b1.M_in = JUNK; b1.in_first = ~first; b1.in_last = ~last;
    endtask

    task automatic wait_done1(output int n);
        n = 0;
        while (!b1.out_valid && n < 300) begin @(posedge clk); #1; n++; end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #2;
        n_cmp++; if (b1.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_r1: got %b want 1", b1.in_ready); end
        n_cmp++; if (b1.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid_r1: got %b want 0", b1.out_valid); end
        n_cmp++; if (b1.H_out !== 256'h0) begin n_bad++; $display("FAIL reset_h_out_r1: got %h want 0", b1.H_out); end
        n_cmp++; if (b4.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_r4: got %b want 1", b4.in_ready); end
        n_cmp++; if (b4.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid_r4: got %b want 0", b4.out_valid); end
        n_cmp++; if (b4.H_out !== 256'h0) begin n_bad++; $display("FAIL reset_h_out_r4: got %h want 0", b4.H_out); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abc;
        int n;
        accept1(MSG_ABC, 1'b1, 1'b1);
        n_cmp++; if (b1.in_ready !== 1'b0) begin n_bad++; $display("FAIL abc_round_in_ready: got %b want 0", b1.in_ready); end
        n_cmp++; if (b1.H_out !== 256'h0) begin n_bad++; $display("FAIL abc_round_h_out: got %h want 0", b1.H_out); end
        wait_done1(n);
        n_cmp++; if (n !== 65) begin n_bad++; $display("FAIL abc_latency: got %0d want 65", n); end
        n_cmp++; if (b1.H_out !== DIG_ABC) begin n_bad++; $display("FAIL abc_digest: got %h want %h", b1.H_out, DIG_ABC); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int n;
        bit saw;
        accept1(MSG_2A, 1'b1, 1'b0);
        b1.M_in = MSG_2B; b1.in_first = 1'b0; b1.in_last = 1'b1; b1.in_valid = 1'b1;
        n = 0; saw = 1'b0;
        while (!b1.in_ready && n < 300) begin
            if (b1.out_valid) saw = 1'b1;
            @(posedge clk); #1; n++;
        end
        if (b1.out_valid) saw = 1'b1;
        n_cmp++; if (n !== 65) begin n_bad++; $display("FAIL two_block_ready_gap: got %0d want 65", n); end
        n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL two_block_early_valid: got %b want 0", saw); end
        @(posedge clk); #1;
        b1.in_valid = 1'b0; b1.M_in = JUNK; b1.in_first = 1'b1; b1.in_last = 1'b0;
        wait_done1(n);
        n_cmp++; if (n !== 65) begin n_bad++; $display("FAIL two_block_latency: got %0d want 65", n); end
        n_cmp++; if (b1.H_out !== DIG_2) begin n_bad++; $display("FAIL two_block_digest: got %h want %h", b1.H_out, DIG_2); end
        @(posedge clk); #1;
    endtask

    task automatic test_null_r4;
        int n;
        b4.M_in = MSG_NULL; b4.in_first = 1'b1; b4.in_last = 1'b1; b4.in_valid = 1'b1;
        @(posedge clk); #1;
        b4.in_valid = 1'b0; b4.M_in = JUNK;
        n = 0;
        while (!b4.out_valid && n < 100) begin @(posedge clk); #1; n++; end
        n_cmp++; if (n !== 17) begin n_bad++; $display("FAIL null_r4_latency: got %0d want 17", n); end
        n_cmp++; if (b4.H_out !== DIG_NULL) begin n_bad++; $display("FAIL null_r4_digest: got %h want %h", b4.H_out, DIG_NULL); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int n, bad;
        b1.out_ready = 1'b0;
        accept1(MSG_ABC, 1'b1, 1'b1);
        wait_done1(n);
        b1.M_in = MSG_NULL; b1.in_first = 1'b1; b1.in_last = 1'b1; b1.in_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (b1.out_valid !== 1'b1 || b1.H_out !== DIG_ABC || b1.in_ready !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
        b1.out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (b1.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", b1.in_ready); end
        n_cmp++; if (b1.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b want 0", b1.out_valid); end
        n_cmp++; if (b1.H_out !== 256'h0) begin n_bad++; $display("FAIL bp_release_h_out: got %h want 0", b1.H_out); end
        b1.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_after_done;
        int n;
        accept1(MSG_ABC, 1'b0, 1'b1);
        wait_done1(n);
        n_cmp++; if (b1.H_out !== DIG_ABC) begin n_bad++; $display("FAIL after_done_digest: got %h want %h", b1.H_out, DIG_ABC); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int n;
        accept1(MSG_ABC, 1'b1, 1'b1);
        repeat (30) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (b1.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset_ready: got %b want 1", b1.in_ready); end
        n_cmp++; if (b1.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid: got %b want 0", b1.out_valid); end
        b1.M_in = MSG_ABC; b1.in_first = 1'b0; b1.in_last = 1'b1; b1.in_valid = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (b1.in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset_first_accept: got in_ready %b want 0", b1.in_ready); end
        b1.in_valid = 1'b0; b1.M_in = JUNK; b1.in_first = 1'b1;
        wait_done1(n);
        n_cmp++; if (n !== 65) begin n_bad++; $display("FAIL mid_reset_latency: got %0d want 65", n); end
        n_cmp++; if (b1.H_out !== DIG_ABC) begin n_bad++; $display("FAIL mid_reset_digest: got %h want %h", b1.H_out, DIG_ABC); end
        @(posedge clk); #1;
    endtask

`ifdef SHA224_MODE_EN
    task automatic test_sha224;
        int n;
        b1.mode_224 = 1'b1;
        accept1(MSG_ABC, 1'b1, 1'b1);
        b1.mode_224 = 1'b0;
        wait_done1(n);
        n_cmp++; if (b1.H_out !== DIG_224) begin n_bad++; $display("FAIL sha224_digest: got %h want %h", b1.H_out, DIG_224); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        rst = 1'b0;
        b1.in_valid = 1'b0; b1.M_in = '0; b1.in_first = 1'b0; b1.in_last = 1'b0; b1.out_ready = 1'b1;
        b4.in_valid = 1'b0; b4.M_in = '0; b4.in_first = 1'b0; b4.in_last = 1'b0; b4.out_ready = 1'b1;
`ifdef SHA224_MODE_EN
        b1.mode_224 = 1'b0;
        b4.mode_224 = 1'b0;
`endif
        test_reset;
        test_abc;
        test_back_to_back;
        test_null_r4;
        test_backpressure;
        test_after_done;
        test_reset_mid;
`ifdef SHA224_MODE_EN
        test_sha224;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sha256_stream.md
SHA256_STREAM -- requirements
Module: sha256_stream

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1: compression rounds per clock; legal values 1, 2, 4; any other value SHALL fail elaboration.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: a message block is offered.
REQ-005 SHALL have port in_ready, output, 1: the block is accepted on an edge where in_valid and in_ready are both high.
REQ-006 SHALL have port M_in, input, 512: padded block, big-endian, word 0 in bits [511:480].
REQ-007 SHALL have port in_first, input, 1: the block starts a new message.
REQ-008 SHALL have port in_last, input, 1: the block ends the message.
REQ-009 SHALL have port out_valid, output, 1: the digest is valid.
REQ-010 SHALL have port out_ready, input, 1: the consumer takes the digest.
REQ-011 SHALL have port H_out, output, 256: digest, big-endian, H0 in bits [255:224].

Function
REQ-012 SHALL implement FSM states IDLE, ROUND, FINAL and DONE.
- IDLE: in_ready=1.
- Accept: go to ROUND; latch M_in, in_last and the working variables a..h.
REQ-013 Working variable source at accept:
- in_first=1: a..h SHALL load from the IV.
- in_first=0: a..h SHALL load from the chaining register.
REQ-014 ROUND SHALL:
- run ROUNDS_PER_CYCLE rounds per cycle for 64/ROUNDS_PER_CYCLE cycles;
- use a 6-bit round counter;
- generate the schedule with a 16-word sliding window.
REQ-015 FINAL SHALL last one cycle and add a..h into the chaining value, mod 2^32 per word.
- Latched in_last=0: go to IDLE.
- Latched in_last=1: go to DONE.
REQ-016 With the accept on edge k, out_valid SHALL rise after edge k+64/ROUNDS_PER_CYCLE+1 (65 cycles for R=1, 17 for R=4).
REQ-017 In DONE:
- out_valid SHALL stay high and H_out SHALL stay stable until out_ready=1.
- On that edge, return to IDLE; in_ready SHALL be high in the next cycle.
REQ-018 in_ready SHALL be 0 in ROUND, FINAL and DONE.
- in_valid SHALL be ignored in those states.
- Changes to M_in, in_first and in_last after accept SHALL have no effect.
REQ-019 A block with in_first=in_last=1 SHALL be a complete single-block message.
REQ-020 A block with in_first=0 arriving after reset or after DONE SHALL chain from the IV, because the chaining register holds the IV in those cases.
REQ-021 H_out SHALL read 0 whenever out_valid=0.

Reset
REQ-022 rst=1 SHALL asynchronously force all of the following, aborting any block in flight:
- state IDLE;
- in_ready=1, out_valid=0, H_out=0;
- round counter 0;
- chaining register = SHA-256 IV.
REQ-023 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-024 With SHA224_MODE_EN defined, the module SHALL:
- add port mode_224, input, 1, sampled at accept when in_first=1;
- when mode_224=1, use the SHA-224 IV;
- output the digest as H0..H6 in bits [255:32] with bits [31:0]=0.
REQ-025 Without SHA224_MODE_EN, there SHALL be no mode_224 port and the behaviour SHALL be SHA-256 only.

Structure
REQ-026 Package sha256_pkg SHALL hold:
- the 64 K constants;
- the SHA-256 and SHA-224 IVs;
- the FSM state enum;
- the Sigma0/1 and sigma0/1 functions.
REQ-027 One sub-module, sha256_round, SHALL implement a single combinational round (a..h, W, K in; a..h out), instantiated ROUNDS_PER_CYCLE times in a chain.

Verification
REQ-028 Single-block "abc" (616263 80..0 ...18), first=last=1, R=1 -> out_valid after 65 cycles, H_out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-029 Two-block "abcdbcdecdef...nopq" (length 0x1C0), blocks sent back-to-back -> H_out=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, and out_valid stays low after block 1.
REQ-030 Null message (80 0..0), R=4 -> out_valid after 17 cycles, H_out=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-031 Backpressure: out_ready=0 for 10 cycles in DONE, with in_valid=1 and a new block offered -> digest held, no accept; with out_ready=1, in_ready rises on the next cycle.
REQ-032 Reset mid-ROUND (cycle 30), then "abc" with first=0 -> correct "abc" digest (chaining from the IV).
REQ-033 SHA224_MODE_EN defined, mode_224=1, "abc" -> H_out[255:32]=23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, H_out[31:0]=0.
